// File: rtl/tpu_seq_ctrl.sv
// Sequencer for one systolic matmul job: fetch -> settle -> weight write -> compute -> flush -> done.
// Optional abort/aborted ports are compiled in when TPU_SEQ_ABORT_EN is defined.
module tpu_seq_ctrl #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_W       = 8,
  parameter int SETTLE_CYC   = 16,
  parameter int FLUSH_CYC    = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                weight_base,
  input  logic [ADDR_W-1:0]                input_base,
  input  logic [ADDR_W-1:0]                output_base,
  input  logic [ADDR_W-1:0]                num_rows,
`ifdef TPU_SEQ_ABORT_EN
  input  logic                             abort,
  output logic                             aborted,
`endif
  output logic                             busy,
  output logic                             done,
  output logic [WIDTH_HEIGHT-1:0]          weightMem_rd_en,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0]   weightMem_rd_addr,
  output logic                             load_weights_to_array,
  output logic [WIDTH_HEIGHT-1:0]          weight_write,
  output logic                             active,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0]   inputMem_rd_addr_base,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0]   outputMem_wr_addr_base
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETTLE, S_WWRITE, S_COMPUTE, S_FLUSH, S_DONE
  } state_t;

  // Counter must hold num_rows + 2*WIDTH_HEIGHT - 2 as well as the settle/flush lengths.
  localparam int SKEW_W = $clog2(2 * WIDTH_HEIGHT);
  localparam int CW0    = (ADDR_W > SKEW_W) ? ADDR_W : SKEW_W;
  localparam int IDLE_W = $clog2(SETTLE_CYC + FLUSH_CYC + 1);
  localparam int CNT_W  = ((CW0 > IDLE_W) ? CW0 : IDLE_W) + 1;

  localparam logic [CNT_W-1:0] FETCH_LEN  = CNT_W'(WIDTH_HEIGHT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LEN = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] FLUSH_LEN  = CNT_W'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] SKEW_LEN   = CNT_W'(2 * WIDTH_HEIGHT - 2);

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [ADDR_W-1:0]  rows_q, rows_n;
  logic [ADDR_W-1:0]  lane_addr_q, lane_addr_n;
  logic [ADDR_W-1:0]  in_base_q, in_base_n;
  logic [ADDR_W-1:0]  out_base_q, out_base_n;
  logic               abort_hit;

`ifdef TPU_SEQ_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q - CNT_W'(1);
    rows_n      = rows_q;
    lane_addr_n = '0;
    in_base_n   = in_base_q;
    out_base_n  = out_base_q;

    case (state_q)
      S_IDLE: begin
        cnt_n = '0;
        if (start) begin
          rows_n     = num_rows;
          in_base_n  = input_base;
          out_base_n = output_base;
          if (num_rows != '0) begin
            state_n     = S_FETCH;
            cnt_n       = FETCH_LEN;
            lane_addr_n = weight_base;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (cnt_q == '0) begin
          if (SETTLE_CYC > 0) begin
            state_n = S_SETTLE;
            cnt_n   = SETTLE_LEN;
          end else begin
            state_n = S_WWRITE;
            cnt_n   = FETCH_LEN;
          end
        end else begin
          lane_addr_n = lane_addr_q + ADDR_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_n = S_WWRITE;
          cnt_n   = FETCH_LEN;
        end
      end
      S_WWRITE: begin
        if (cnt_q == '0) begin
          state_n = S_COMPUTE;
          cnt_n   = CNT_W'(rows_q) + SKEW_LEN;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == '0) begin
          if (FLUSH_CYC > 0) begin
            state_n = S_FLUSH;
            cnt_n   = FLUSH_LEN;
          end else begin
            state_n = S_DONE;
            cnt_n   = '0;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Abort overrides whatever transition the state wanted.
    if (abort_hit) begin
      state_n     = S_IDLE;
      cnt_n       = '0;
      lane_addr_n = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q               <= S_IDLE;
      cnt_q                 <= '0;
      rows_q                <= '0;
      lane_addr_q           <= '0;
      in_base_q             <= '0;
      out_base_q            <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      weightMem_rd_en       <= '0;
      load_weights_to_array <= 1'b0;
      weight_write          <= '0;
      active                <= 1'b0;
    end else begin
      state_q               <= state_n;
      cnt_q                 <= cnt_n;
      rows_q                <= rows_n;
      lane_addr_q           <= lane_addr_n;
      in_base_q             <= in_base_n;
      out_base_q            <= out_base_n;
      busy                  <= (state_n != S_IDLE);
      done                  <= (state_n == S_DONE);
      weightMem_rd_en       <= {WIDTH_HEIGHT{state_n == S_FETCH}};
      load_weights_to_array <= (state_n == S_FETCH) || (state_n == S_WWRITE);
      weight_write          <= {WIDTH_HEIGHT{state_n == S_WWRITE}};
      active                <= (state_n == S_COMPUTE);
    end
  end

`ifdef TPU_SEQ_ABORT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) aborted <= 1'b0;
    else       aborted <= abort_hit;
  end
`endif

  // Every lane sees the same registered value, lane 0 in the LSBs.
  assign weightMem_rd_addr      = {WIDTH_HEIGHT{lane_addr_q}};
  assign inputMem_rd_addr_base  = {WIDTH_HEIGHT{in_base_q}};
  assign outputMem_wr_addr_base = {WIDTH_HEIGHT{out_base_q}};

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboard bench for tpu_seq_ctrl: a per-cycle expected output stream is queued at each start
// and compared every cycle; abort scenario is exercised when TPU_SEQ_ABORT_EN is defined.
module tb_tpu_seq_ctrl;
  localparam int WH = 16;
  localparam int AW = 8;
  localparam int SC = 16;
  localparam int FC = 3;

  logic clk = 1'b0;
  logic reset, start;
  logic [AW-1:0] weight_base, input_base, output_base, num_rows;
  logic busy, done, load_weights_to_array, active;
  logic [WH-1:0] weightMem_rd_en, weight_write;
  logic [WH*AW-1:0] weightMem_rd_addr, inputMem_rd_addr_base, outputMem_wr_addr_base;
`ifdef TPU_SEQ_ABORT_EN
  logic abort, aborted;
`endif

  always #5 clk = ~clk;

  tpu_seq_ctrl #(.WIDTH_HEIGHT(WH), .ADDR_W(AW), .SETTLE_CYC(SC), .FLUSH_CYC(FC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .weight_base(weight_base), .input_base(input_base),
    .output_base(output_base), .num_rows(num_rows),
`ifdef TPU_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done),
    .weightMem_rd_en(weightMem_rd_en), .weightMem_rd_addr(weightMem_rd_addr),
    .load_weights_to_array(load_weights_to_array), .weight_write(weight_write),
    .active(active), .inputMem_rd_addr_base(inputMem_rd_addr_base),
    .outputMem_wr_addr_base(outputMem_wr_addr_base)
  );

  typedef struct packed {
    logic           busy;
    logic           done;
    logic [WH-1:0]  rd_en;
    logic [WH*AW-1:0] rd_addr;
    logic           load;
    logic [WH-1:0]  ww;
    logic           active;
    logic [WH*AW-1:0] in_base;
    logic [WH*AW-1:0] out_base;
    logic           aborted;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;

  function automatic logic [WH*AW-1:0] rep(input logic [AW-1:0] v);
    logic [WH*AW-1:0] r;
    for (int i = 0; i < WH; i++) r[i*AW +: AW] = v;
    return r;
  endfunction

  function automatic obs_t idle_e(input logic [AW-1:0] ib, input logic [AW-1:0] ob);
    obs_t e;
    e = '0;
    e.in_base  = rep(ib);
    e.out_base = rep(ob);
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t a;
    a.busy     = busy;
    a.done     = done;
    a.rd_en    = weightMem_rd_en;
    a.rd_addr  = weightMem_rd_addr;
    a.load     = load_weights_to_array;
    a.ww       = weight_write;
    a.active   = active;
    a.in_base  = inputMem_rd_addr_base;
    a.out_base = outputMem_wr_addr_base;
`ifdef TPU_SEQ_ABORT_EN
    a.aborted  = aborted;
`else
    a.aborted  = 1'b0;
`endif
    return a;
  endfunction

  // Expected cycle-by-cycle outputs of one job, starting with the cycle after the start edge.
  task automatic push_job(input logic [AW-1:0] wb, input logic [AW-1:0] rows,
                          input logic [AW-1:0] ib, input logic [AW-1:0] ob, input bit tail);
    obs_t e;
    if (rows != '0) begin
      for (int k = 0; k < WH; k++) begin
        e = idle_e(ib, ob); e.busy = 1'b1; e.rd_en = '1; e.load = 1'b1;
        e.rd_addr = rep(AW'(int'(wb) + k));
        exp_q.push_back(e);
      end
      for (int k = 0; k < SC; k++) begin
        e = idle_e(ib, ob); e.busy = 1'b1; exp_q.push_back(e);
      end
      for (int k = 0; k < WH; k++) begin
        e = idle_e(ib, ob); e.busy = 1'b1; e.load = 1'b1; e.ww = '1; exp_q.push_back(e);
      end
      for (int k = 0; k < int'(rows) + 2*WH - 1; k++) begin
        e = idle_e(ib, ob); e.busy = 1'b1; e.active = 1'b1; exp_q.push_back(e);
      end
      for (int k = 0; k < FC; k++) begin
        e = idle_e(ib, ob); e.busy = 1'b1; exp_q.push_back(e);
      end
    end
    e = idle_e(ib, ob); e.busy = 1'b1; e.done = 1'b1; exp_q.push_back(e);
    if (tail) exp_q.push_back(idle_e(ib, ob));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input logic [AW-1:0] wb, input logic [AW-1:0] rows,
                           input logic [AW-1:0] ib, input logic [AW-1:0] ob);
    weight_base = wb; num_rows = rows; input_base = ib; output_base = ob;
  endtask

  // hook_kind: 0 none, 1 extra start pulse, 2 drop held start, 3 abort, 4 async reset pulse.
  task automatic run_expect(input string name, input int hook_idx, input int hook_kind,
                            input logic [AW-1:0] ib, input logic [AW-1:0] ob);
    obs_t e, a;
    int idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = observe();
      checks++;
      if (a.busy) busy_cycles++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, idx, a, e);
      end
      if (idx == hook_idx) begin
        case (hook_kind)
          1: begin start = 1'b1; num_rows = num_rows + 8'd7; end
          2: start = 1'b0;
`ifdef TPU_SEQ_ABORT_EN
          3: begin
            abort = 1'b1;
            exp_q.delete();
            e = idle_e(ib, ob); e.aborted = 1'b1; exp_q.push_back(e);
            exp_q.push_back(idle_e(ib, ob));
          end
`endif
          4: begin
            #3 reset = 1'b1;
            #1;
            a = observe();
            checks++;
            if (a !== obs_t'('0)) begin
              errors++;
              $display("FAIL %s async_reset_clear: got %h expected 0", name, a);
            end
            #2 reset = 1'b0;
            exp_q.delete();
          end
          default: ;
        endcase
      end
      if (idx == hook_idx + 1) begin
        if (hook_kind == 1) start = 1'b0;
`ifdef TPU_SEQ_ABORT_EN
        if (hook_kind == 3) abort = 1'b0;
`endif
      end
      step();
      idx++;
    end
  endtask

  task automatic test_reset();
    obs_t a;
    reset = 1'b1; start = 1'b0;
    drive_cfg('0, '0, '0, '0);
`ifdef TPU_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    step(); step();
    a = observe();
    checks++;
    if (a !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", a);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_job();
    drive_cfg(8'h00, 8'd16, 8'h12, 8'h34);
    push_job(8'h00, 8'd16, 8'h12, 8'h34, 1'b1);
    busy_cycles = 0;
    start = 1'b1; step(); start = 1'b0;
    run_expect("basic_job", -1, 0, 8'h12, 8'h34);
    checks++;
    if (busy_cycles != 2*WH + SC + (16 + 2*WH - 1) + FC + 1) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d expected 99", busy_cycles);
    end
  endtask

  task automatic test_addr_wrap();
    drive_cfg(8'hF8, 8'd4, 8'h55, 8'hAA);
    push_job(8'hF8, 8'd4, 8'h55, 8'hAA, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    run_expect("addr_wrap", -1, 0, 8'h55, 8'hAA);
  endtask

  task automatic test_zero_rows();
    drive_cfg(8'h03, 8'd0, 8'h01, 8'h02);
    push_job(8'h03, 8'd0, 8'h01, 8'h02, 1'b1);
    exp_q.push_back(idle_e(8'h01, 8'h02));
    start = 1'b1; step(); start = 1'b0;
    run_expect("zero_rows", -1, 0, 8'h01, 8'h02);
  endtask

  task automatic test_ignored_start();
    drive_cfg(8'h10, 8'd5, 8'h21, 8'h43);
    push_job(8'h10, 8'd5, 8'h21, 8'h43, 1'b1);
    exp_q.push_back(idle_e(8'h21, 8'h43));
    start = 1'b1; step(); start = 1'b0;
    run_expect("ignored_start", 2*WH + SC + 3, 1, 8'h21, 8'h43);
  endtask

  task automatic test_reset_mid_job();
    obs_t a;
    int bad = 0;
    drive_cfg(8'h00, 8'd3, 8'h66, 8'h77);
    push_job(8'h00, 8'd3, 8'h66, 8'h77, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    run_expect("reset_mid_job", 2*WH + SC - 11, 4, 8'h66, 8'h77);
    for (int i = 0; i < 20; i++) begin
      a = observe();
      if (a.busy !== 1'b0 || a.done !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d busy/done cycles expected 0", bad);
    end
    drive_cfg(8'h01, 8'd2, 8'h09, 8'h0A);
    push_job(8'h01, 8'd2, 8'h09, 8'h0A, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    run_expect("after_reset_job", -1, 0, 8'h09, 8'h0A);
  endtask

  task automatic test_back_to_back();
    int job_len;
    job_len = 2*WH + SC + (1 + 2*WH - 1) + FC + 1;
    drive_cfg(8'h20, 8'd1, 8'h30, 8'h40);
    push_job(8'h20, 8'd1, 8'h30, 8'h40, 1'b1);
    push_job(8'h20, 8'd1, 8'h30, 8'h40, 1'b1);
    exp_q.push_back(idle_e(8'h30, 8'h40));
    start = 1'b1; step();
    run_expect("back_to_back", job_len + 1, 2, 8'h30, 8'h40);
    start = 1'b0;
  endtask

  task automatic test_abort();
    drive_cfg(8'h00, 8'd8, 8'h5A, 8'hA5);
    push_job(8'h00, 8'd8, 8'h5A, 8'hA5, 1'b1);
    start = 1'b1; step(); start = 1'b0;
`ifdef TPU_SEQ_ABORT_EN
    run_expect("abort", 2*WH + SC + 2, 3, 8'h5A, 8'hA5);
`else
    run_expect("no_abort_job", -1, 0, 8'h5A, 8'hA5);
`endif
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_addr_wrap();
    test_zero_rows();
    test_ignored_start();
    test_reset_mid_job();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
